// File: rtl/ofifo_pkg.sv
// Shared defaults and width helpers for the south-edge output collector.
package ofifo_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int DEPTH_DEF   = 64;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-column first-word-fall-through FIFO; 1-cycle write-to-read latency.
// A push into a full column is accepted only when a pop happens in the same cycle, otherwise it is dropped.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int depth   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               drop
);

  localparam int PW = ptr_w(depth);
  localparam int CW = cnt_w(depth);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [psum_bw-1:0] mem_q [depth];
  logic               pop_ok;
  logic               push;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(depth));
  assign pop_ok = pop && !empty;
  // When full, the slot being written is the head being popped this cycle.
  assign push   = wr && (!full || pop_ok);
  assign drop   = wr && full && !pop_ok;
  assign dout   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ofifo_collect.sv
// Aligns skewed per-column partial sums into full rows; row valid when every column FIFO is non-empty.
// Optional build macro OFIFO_RELU_EN clamps negative head values to zero on the output.
module ofifo_collect
  import ofifo_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int depth   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic                   o_valid,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_full,
  output logic                   overflow
);

  logic [col-1:0]     empty;
  logic [col-1:0]     full;
  logic [col-1:0]     drop;
  logic [psum_bw-1:0] head [col];
  logic               pop;
  logic               overflow_q, overflow_d;

  assign pop = rd && o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[c]),
      .pop   (pop),
      .din   (in[psum_bw*c +: psum_bw]),
      .dout  (head[c]),
      .empty (empty[c]),
      .full  (full[c]),
      .drop  (drop[c])
    );
  end

  assign o_valid    = ~|empty;
  assign o_full     = |full;
  assign overflow_d = overflow_q | (|drop);
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  always_comb begin
    out = '0;
    if (o_valid) begin
      for (int c = 0; c < col; c++) begin
`ifdef OFIFO_RELU_EN
        out[psum_bw*c +: psum_bw] = head[c][psum_bw-1] ? '0 : head[c];
`else
        out[psum_bw*c +: psum_bw] = head[c];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ofifo_collect.sv
// Directed self-checking bench for ofifo_collect (col=8, psum_bw=16, depth=4).
module tb_ofifo_collect;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 4;
  localparam int W   = COL * BW;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_d;
  logic [COL-1:0] wr;
  logic           rd;
  logic           o_valid;
  logic [W-1:0]   out_d;
  logic           o_full;
  logic           overflow;

  int n_checks;
  int n_fail;

  ofifo_collect #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .in       (in_d),
    .wr       (wr),
    .rd       (rd),
    .o_valid  (o_valid),
    .out      (out_d),
    .o_full   (o_full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [COL-1:0] wr;
    logic [W-1:0]   din;
    logic           rd;
    logic           exp_vld;
    logic           exp_full;
    logic           exp_ovf;
    logic [W-1:0]   exp_out;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [W-1:0] row_val(input int base);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[BW*c +: BW] = BW'(base + c);
    return r;
  endfunction

  function automatic logic [W-1:0] splat(input logic [BW-1:0] v);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[BW*c +: BW] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    wr   = w;
    in_d = d;
    rd   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr    = '0;
    rd    = 1'b0;
    in_d  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [W-1:0] exp_row;
  logic [W-1:0] relu_in;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Skewed fill table: column c pushes 0x0100+c on step c, then one row is read.
    for (int c = 0; c < COL; c++) begin
      vecs[c].wr       = COL'(1) << c;
      vecs[c].din      = splat(BW'(16'h0100 + c));
      vecs[c].rd       = 1'b0;
      vecs[c].exp_vld  = (c == COL - 1);
      vecs[c].exp_full = 1'b0;
      vecs[c].exp_ovf  = 1'b0;
      vecs[c].exp_out  = (c == COL - 1) ? row_val(16'h0100) : '0;
    end
    for (int k = 8; k < 10; k++) begin
      vecs[k].wr       = '0;
      vecs[k].din      = '0;
      vecs[k].rd       = 1'b1;
      vecs[k].exp_vld  = 1'b0;
      vecs[k].exp_full = 1'b0;
      vecs[k].exp_ovf  = 1'b0;
      vecs[k].exp_out  = '0;
    end

    // Reset state and idle read.
    do_reset();
    check("reset o_valid", W'(o_valid), '0);
    check("reset out", out_d, '0);
    check("reset o_full", W'(o_full), '0);
    check("reset overflow", W'(overflow), '0);
    step('0, '0, 1'b1);
    check("idle rd o_valid", W'(o_valid), '0);
    check("idle rd overflow", W'(overflow), '0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].wr, vecs[i].din, vecs[i].rd);
      check($sformatf("skew[%0d] o_valid", i), W'(o_valid), W'(vecs[i].exp_vld));
      check($sformatf("skew[%0d] o_full", i), W'(o_full), W'(vecs[i].exp_full));
      check($sformatf("skew[%0d] overflow", i), W'(overflow), W'(vecs[i].exp_ovf));
      check($sformatf("skew[%0d] out", i), out_d, vecs[i].exp_out);
    end

    // Back-to-back stream with rd held high.
    do_reset();
    for (int r = 0; r < 100; r++) begin
      step('1, row_val(r * 16), 1'b1);
      check($sformatf("stream[%0d] out", r), out_d, row_val(r * 16));
      check($sformatf("stream[%0d] o_full", r), W'(o_full), '0);
    end
    step('0, '0, 1'b1);
    check("stream drained o_valid", W'(o_valid), '0);
    check("stream overflow", W'(overflow), '0);

    // Full boundary on column 0 only.
    do_reset();
    for (int i = 0; i < DEP; i++) step(COL'(1), splat(BW'(16'h00A0 + i)), 1'b0);
    check("col0 full o_full", W'(o_full), W'(1));
    check("col0 full overflow", W'(overflow), '0);
    check("col0 full o_valid", W'(o_valid), '0);
    step(COL'(1), splat(16'h00A4), 1'b0);
    check("drop overflow", W'(overflow), W'(1));
    step(8'hFE, splat(16'h00B0), 1'b0);
    exp_row = splat(16'h00B0);
    exp_row[BW-1:0] = 16'h00A0;
    check("drop head unchanged", out_d, exp_row);
    check("overflow sticky", W'(overflow), W'(1));
    do_reset();
    check("midstream reset o_valid", W'(o_valid), '0);
    check("midstream reset o_full", W'(o_full), '0);
    check("midstream reset overflow", W'(overflow), '0);

    // Simultaneous push/pop at full.
    for (int k = 0; k < DEP; k++) step('1, row_val(16'h1000 + k * 16), 1'b0);
    check("all full o_full", W'(o_full), W'(1));
    check("all full head", out_d, row_val(16'h1000));
    step('1, splat(16'h7FFF), 1'b1);
    check("pushpop overflow", W'(overflow), '0);
    check("pushpop o_full", W'(o_full), W'(1));
    check("pushpop head", out_d, row_val(16'h1010));
    step('0, '0, 1'b1);
    check("pop1 head", out_d, row_val(16'h1020));
    step('0, '0, 1'b1);
    check("pop2 head", out_d, row_val(16'h1030));
    check("pop2 o_full", W'(o_full), '0);
    step('0, '0, 1'b1);
    check("pop3 head 7FFF", out_d, splat(16'h7FFF));
    step('0, '0, 1'b1);
    check("pushpop drained", W'(o_valid), '0);
    check("pushpop final overflow", W'(overflow), '0);

    // Negative head value: raw or clamped depending on build.
    do_reset();
    relu_in = '0;
    relu_in[BW-1:0]    = 16'hFFF6;
    relu_in[2*BW-1:BW] = 16'h000A;
    step('1, relu_in, 1'b0);
    exp_row = '0;
`ifdef OFIFO_RELU_EN
    exp_row[BW-1:0] = 16'h0000;
`else
    exp_row[BW-1:0] = 16'hFFF6;
`endif
    exp_row[2*BW-1:BW] = 16'h000A;
    check("relu out", out_d, exp_row);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
